// File: rtl/router_pkt_tx.sv
// router_pkt_tx: host-side packet transmitter for a byte-wide router port.
// A command (addr, len) is accepted, the full payload is staged in a local
// buffer, then header, payload and an XOR parity byte are streamed to the
// router, honouring its busy back-pressure with an abort on prolonged stalls.
module router_pkt_tx #(
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_addr,
    input  logic [5:0]  cmd_len,
    input  logic        pay_valid,
    output logic        pay_ready,
    input  logic [7:0]  pay_data,
    input  logic        busy,
    output logic        pkt_valid,
    output logic [7:0]  data_out,
    output logic        tx_done,
    output logic        cmd_err,
    output logic        timeout,
    output logic [15:0] pkt_cnt
);

    localparam int STALL_W = $clog2(BUSY_TIMEOUT + 1);
    // The abort fires on the edge that would bring the stall count to BUSY_TIMEOUT.
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_PARITY  = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    // Running parity is a plain XOR fold of every byte handed to the router.
    function automatic logic [7:0] par_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t              r_state;
    logic [1:0]          r_addr;
    logic [5:0]          r_len;
    logic [5:0]          r_idx;
    logic [7:0]          r_par;
    logic [STALL_W-1:0]  r_stall;
    logic [7:0]          r_mem [0:63];
    logic                r_pkt_valid;
    logic [7:0]          r_data_out;
    logic                r_tx_done;
    logic                r_cmd_err;
    logic                r_timeout;
    logic [15:0]         r_pkt_cnt;

    state_t              w_state_nxt;
    logic [5:0]          w_idx_nxt;
    logic [7:0]          w_par_nxt;
    logic [STALL_W-1:0]  w_stall_nxt;
    logic                w_latch_cmd;
    logic                w_mem_we;
    logic                w_cmd_err_nxt;
    logic                w_tx_done_nxt;
    logic                w_timeout_nxt;
    logic                w_in_tx;
    logic                w_abort;
    logic                w_last_idx;
    logic                w_pv_nxt;
    logic [7:0]          w_dout_nxt;

    assign cmd_ready = (r_state == S_IDLE);
    assign pay_ready = (r_state == S_LOAD);
    assign pkt_valid = r_pkt_valid;
    assign data_out  = r_data_out;
    assign tx_done   = r_tx_done;
    assign cmd_err   = r_cmd_err;
    assign timeout   = r_timeout;
    assign pkt_cnt   = r_pkt_cnt;

    assign w_in_tx    = (r_state == S_HEADER) || (r_state == S_PAYLOAD) || (r_state == S_PARITY);
    assign w_abort    = w_in_tx && busy && (r_stall == STALL_LAST);
    assign w_last_idx = (r_idx == (r_len - 6'd1));

    // Next-state, index, parity and pulse decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_par_nxt     = r_par;
        w_latch_cmd   = 1'b0;
        w_mem_we      = 1'b0;
        w_cmd_err_nxt = 1'b0;
        w_tx_done_nxt = 1'b0;
        w_timeout_nxt = 1'b0;

        if (w_in_tx && busy && !w_abort) begin
            w_stall_nxt = r_stall + STALL_W'(1);
        end else begin
            w_stall_nxt = '0;
        end

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_addr != 2'd3) && (cmd_len != 6'd0)) begin
                        w_latch_cmd = 1'b1;
                        w_idx_nxt   = 6'd0;
                        w_par_nxt   = 8'h00;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (pay_valid) begin
                    w_mem_we = 1'b1;
                    if (w_last_idx) begin
                        w_idx_nxt   = 6'd0;
                        w_state_nxt = S_HEADER;
                    end else begin
                        w_idx_nxt = r_idx + 6'd1;
                    end
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_HEADER: begin
                if (w_abort) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else if (!busy) begin
                    w_par_nxt   = par_fold(r_par, {r_len, r_addr});
                    w_idx_nxt   = 6'd0;
                    w_state_nxt = S_PAYLOAD;
                end else begin
                    w_state_nxt = S_HEADER;
                end
            end
            S_PAYLOAD: begin
                if (w_abort) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else if (!busy) begin
                    w_par_nxt = par_fold(r_par, r_mem[r_idx]);
                    if (w_last_idx) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_idx_nxt = r_idx + 6'd1;
                    end
                end else begin
                    w_state_nxt = S_PAYLOAD;
                end
            end
            S_PARITY: begin
                if (w_abort) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else if (!busy) begin
                    w_tx_done_nxt = 1'b1;
                    w_state_nxt   = S_GAP;
                end else begin
                    w_state_nxt = S_PARITY;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Router-side outputs are decoded from the next state so the registers line up with it.
    always_comb begin
        w_pv_nxt   = 1'b0;
        w_dout_nxt = 8'h00;
        case (w_state_nxt)
            S_HEADER: begin
                w_pv_nxt   = 1'b1;
                w_dout_nxt = {r_len, r_addr};
            end
            S_PAYLOAD: begin
                w_pv_nxt   = 1'b1;
                w_dout_nxt = r_mem[w_idx_nxt];
            end
            S_PARITY: begin
                w_pv_nxt   = 1'b0;
                w_dout_nxt = w_par_nxt;
            end
            default: begin
                w_pv_nxt   = 1'b0;
                w_dout_nxt = 8'h00;
            end
        endcase
    end

    // Control state, command latch, index, parity and stall counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_addr  <= 2'd0;
            r_len   <= 6'd0;
            r_idx   <= 6'd0;
            r_par   <= 8'h00;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_par   <= w_par_nxt;
            r_stall <= w_stall_nxt;
            if (w_latch_cmd) begin
                r_addr <= cmd_addr;
                r_len  <= cmd_len;
            end else begin
                r_addr <= r_addr;
                r_len  <= r_len;
            end
        end
    end

    // Registered router outputs, event pulses and completed-packet counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pkt_valid <= 1'b0;
            r_data_out  <= 8'h00;
            r_tx_done   <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_timeout   <= 1'b0;
            r_pkt_cnt   <= 16'h0000;
        end else begin
            r_pkt_valid <= w_pv_nxt;
            r_data_out  <= w_dout_nxt;
            r_tx_done   <= w_tx_done_nxt;
            r_cmd_err   <= w_cmd_err_nxt;
            r_timeout   <= w_timeout_nxt;
            if (w_tx_done_nxt) begin
                r_pkt_cnt <= r_pkt_cnt + 16'h0001;
            end else begin
                r_pkt_cnt <= r_pkt_cnt;
            end
        end
    end

    // Payload staging buffer; contents are only meaningful after a full LOAD.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= pay_data;
        end
    end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001: Parameter BUSY_TIMEOUT, default 64, is the number of consecutive busy cycles after which an in-flight packet is aborted.
REQ-002: clock  input  1  single clock; all state updates on rising edge.
REQ-003: resetn  input  1  asynchronous, active-low reset.
REQ-004: cmd_valid  input  1  host offers a packet command.
REQ-005: cmd_ready  output  1  block accepts the command (transfer on cmd_valid & cmd_ready).
REQ-006: cmd_addr  input  2  destination port 0..2; 3 is invalid.
REQ-007: cmd_len  input  6  payload byte count, 1..63; 0 is invalid.
REQ-008: pay_valid  input  1  host offers a payload byte.
REQ-009: pay_ready  output  1  block accepts the payload byte.
REQ-010: pay_data  input  8  payload byte.
REQ-011: busy  input  1  router busy; a byte transfers to the router only on an edge with busy=0.
REQ-012: pkt_valid  output  1  drives router pkt_valid.
REQ-013: data_out  output  8  drives router data_in.
REQ-014: tx_done  output  1  one-cycle pulse when a packet's parity byte has transferred.
REQ-015: cmd_err  output  1  one-cycle pulse when an invalid command is dropped.
REQ-016: timeout  output  1  one-cycle pulse when a packet is aborted on busy timeout.
REQ-017: pkt_cnt  output  16  count of completed packets, wraps 0xFFFF->0x0000.

Function
REQ-018: The FSM SHALL have states IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
REQ-019: IDLE: cmd_ready=1; on accept with valid addr/len -> LOAD, latch addr, len; with addr=3 or len=0 -> stay IDLE, cmd_err=1 next cycle.
REQ-020: LOAD: pay_ready=1; each accepted byte stored in a 64x8 staging buffer at index 0..len-1; after byte len-1 -> HEADER; pay_ready=0 in every other state.
REQ-021: Transmission SHALL start only after the full payload is buffered, so no payload gap ever reaches the router.
REQ-022: HEADER: pkt_valid=1, data_out={len,addr}; on edge with busy=0 -> PAYLOAD, index 0.
REQ-023: PAYLOAD: pkt_valid=1, data_out=buffer[index]; each edge with busy=0 advances index; after index len-1 transfers -> PARITY.
REQ-024: PARITY: pkt_valid=0, data_out=XOR of header and all payload bytes; on edge with busy=0 -> GAP.
REQ-025: GAP: one cycle, pkt_valid=0, data_out=0x00, tx_done=1, pkt_cnt increments; -> IDLE.
REQ-026: While busy=1 in HEADER/PAYLOAD/PARITY, pkt_valid, data_out and index SHALL hold unchanged.
REQ-027: Parity SHALL be accumulated as bytes transfer, not recomputed; width 8, XOR only.
REQ-028: A busy stall counter SHALL reset to 0 on any edge with busy=0 or outside HEADER/PAYLOAD/PARITY, and increment otherwise.
REQ-029: When the stall counter reaches BUSY_TIMEOUT, next state SHALL be IDLE with pkt_valid=0, data_out=0x00, timeout=1 for one cycle, pkt_cnt unchanged.
REQ-030: cmd_valid asserted outside IDLE and pay_valid outside LOAD SHALL be ignored (not consumed).
REQ-031: tx_done, cmd_err, timeout SHALL never assert in the same cycle.
REQ-032: All outputs SHALL be registered except cmd_ready and pay_ready, which decode state only.

Reset
REQ-033: resetn=0 SHALL immediately force state IDLE, pkt_valid=0, data_out=0x00, tx_done=0, cmd_err=0, timeout=0, pkt_cnt=0, stall counter=0, parity=0, index=0.
REQ-034: Reset mid-packet SHALL discard buffer contents logically; first post-reset packet starts from IDLE with clean parity.
REQ-035: Staging buffer contents need not be reset.

Verification
REQ-036: addr=1, len=3, payload AA BB CC, busy=0 -> data_out 0x0D,AA,BB,CC with pkt_valid=1, then 0xD0 with pkt_valid=0, tx_done, pkt_cnt=1.
REQ-037: Same packet, busy=1 for 5 cycles at payload byte BB -> BB held 5 cycles, no duplicate/skip, parity still 0xD0.
REQ-038: busy held high 64 cycles from HEADER -> timeout pulse, pkt_valid=0, return to IDLE, pkt_cnt unchanged.
REQ-039: cmd addr=3 len=4, then addr=0 len=0 -> two cmd_err pulses, pay_ready never 1, pkt_valid never 1.
REQ-040: addr=2, len=63, payload 0x00..0x3E -> header 0xFE, 63 payload bytes, parity correct, back-to-back second packet after one GAP cycle.
REQ-041: resetn=0 during PAYLOAD index 10 -> pkt_valid=0 immediately; next packet addr=0 len=1 payload 0x55 -> header 0x04, parity 0x51.
